gpr16_bank8_sb: RTL and testbench
=================================

// Module: gpr16_bank8_sb
// PURPOSE
//  8-entry x 16-bit register bank with per-register pending-write scoreboard.
//  Sits directly upstream of the 16-bit 8:1 read mux.
//  - REG0..REG7 drive the mux data inputs; SEL_Q drives its S2..S0 selects.
//  - Byte-lane writeback matches the mux's two 8-bit halves.
//  - Read requests stall while the selected register has writes in flight.
// PARAMETERS
//  DATA_W  16  register width; must be 16 (two byte lanes)
//  NREG    8   register count; must be 8 (3-bit select)
//  CNT_W   2   pending-counter width per register; saturates at 2**CNT_W-1
// PORTS
//  CLK         in   1        clock, all state on rising edge
//  RST         in   1        synchronous reset, active-high
//  ISSUE_EN    in   1        producer issued: increment pending count of ISSUE_SEL
//  ISSUE_SEL   in   3        register targeted by issue
//  ISSUE_FULL  out  1        comb: pending count of ISSUE_SEL is saturated
//  WR_EN       in   1        writeback valid
//  WR_SEL      in   3        writeback register
//  WR_BE       in   2        byte enables: [0]=bits 7:0, [1]=bits 15:8
//  WR_DATA     in   16       writeback data
//  RD_REQ      in   1        read request
//  RD_SEL      in   3        register to read
//  STALL       out  1        comb: RD_REQ && pending(RD_SEL)!=0; request not accepted
//  SEL_Q       out  3        registered select of last accepted read -> mux S2..S0
//  RD_VLD      out  1        one-cycle pulse, cycle after acceptance
//  REG0..REG7  out  16 each  register contents -> mux IN0..IN7
//  ERR_UFLOW   out  1        sticky: writeback arrived with pending count 0
// BEHAVIOUR
//  Reset: REGn=0, all pending counts=0, SEL_Q=0, RD_VLD=0, ERR_UFLOW=0. Reset overrides all inputs.
//  Write: on WR_EN, each lane with WR_BE bit set is loaded; other lanes hold.
//   WR_BE=00 writes no data but still decrements the count.
//  Pending count per register:
//   - ISSUE only: +1, unless saturated. When saturated, the count holds; a
//     producer must not issue while ISSUE_FULL is high (assertion).
//   - WR only: -1 if nonzero; if zero, count stays 0 and ERR_UFLOW sets.
//   - ISSUE and WR to the same register in the same cycle: count unchanged.
//     No underflow is flagged, even when the count was 0.
//   - ISSUE and WR to different registers: each updated independently.
//  Read: accepted when RD_REQ && !STALL.
//   - Next cycle: SEL_Q = RD_SEL and RD_VLD = 1.
//   - Otherwise RD_VLD = 0 and SEL_Q holds.
//   - Read latency is one cycle; mux output is valid while RD_VLD=1.
//  STALL evaluates counts before this cycle's update (see the macro for the exception).
//  ERR_UFLOW clears only on RST.
// CONFIGURATION
//  GPR_BYPASS_EN defined:
//   - REGn outputs show this cycle's WR_DATA lanes combinationally (write-through).
//   - STALL treats a register whose count is 1 and which is written back this
//     cycle, with no same-cycle issue, as not pending.
//   - A read therefore proceeds in the writeback cycle.
//  GPR_BYPASS_EN undefined:
//   - REGn are pure flop outputs.
//   - The read stalls through the writeback cycle and is accepted one cycle later.
// STRUCTURE
//  Shared package gpr_pkg: DATA_W, NREG, SEL_W=3, CNT_W, lane constants LANE_LO/LANE_HI.
//  Sub-module gpr_pend_cnt: one saturating up/down counter.
//   - Inputs: inc, dec. Outputs: nonzero, full, uflow.
//   - Instantiated 8x via generate.
//  Data regs, read-accept logic and bypass mux stay in the top.
// TESTING
//  1. RST mid-operation (count[2]=2, RD_VLD=1) -> next cycle all REGn=0,
//     counts=0, RD_VLD=0, SEL_Q=0.
//  2. WR_EN, WR_SEL=5, WR_BE=01, WR_DATA=0xBEEF over REG5=0x1234 -> REG5=0x12EF
//     next cycle; BE=10 then gives 0xBEEF.
//  3. ISSUE to reg 3, then RD_REQ with RD_SEL=3 -> STALL=1. WR to reg 3 follows:
//     - without macro: accepted 1 cycle after WR, SEL_Q=3, RD_VLD=1;
//     - with macro: accepted in the WR cycle.
//  4. Three ISSUEs to reg 7 -> ISSUE_FULL=1, count=3.
//     Simultaneous ISSUE+WR to reg 7 -> count stays 3.
//  5. WR to reg 0 with count 0 -> data written, count 0, ERR_UFLOW=1,
//     still 1 after 10 idle cycles.
//  6. Back-to-back reads RD_SEL=1,2,4 with no pending writes -> SEL_Q=1,2,4 on
//     consecutive cycles, RD_VLD continuously high.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants and lane helper for the 8x16 register bank with pending-write scoreboard.
package gpr_pkg;
  localparam int DATA_W  = 16;
  localparam int NREG    = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 2;
  localparam int LANE_W  = 8;
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  typedef logic [DATA_W-1:0] word_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic word_t merge_lanes(input word_t old_val, input word_t new_val,
                                        input logic [1:0] be);
    word_t res;
    res = old_val;
    if (be[LANE_LO]) res[LANE_LO*LANE_W +: LANE_W] = new_val[LANE_LO*LANE_W +: LANE_W];
    if (be[LANE_HI]) res[LANE_HI*LANE_W +: LANE_W] = new_val[LANE_HI*LANE_W +: LANE_W];
    return res;
  endfunction
endpackage

// File: rtl/gpr_pend_cnt.sv
// Saturating pending-write counter for one register.
// GPR_BYPASS_EN adds the 'last' output (exactly one write in flight).
module gpr_pend_cnt
  import gpr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
`ifdef GPR_BYPASS_EN
  output logic last,
`endif
  output logic nonzero,
  output logic full,
  output logic uflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  // Simultaneous inc and dec cancel; saturation and zero both hold the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec && !full) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && nonzero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == CNT_MAX);
  assign uflow   = dec && !inc && !nonzero;
`ifdef GPR_BYPASS_EN
  assign last    = (cnt_q == CNT_W'(1));
`endif
endmodule

// File: rtl/gpr16_bank8_sb.sv
// 8x16 register bank with per-register pending-write scoreboard feeding an 8:1 read mux.
// GPR_BYPASS_EN: write-through register outputs and stall release in the writeback cycle.
module gpr16_bank8_sb
  import gpr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [SEL_W-1:0]  issue_sel,
  output logic              issue_full,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [1:0]        wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              stall,
  output logic [SEL_W-1:0]  sel_q,
  output logic              rd_vld,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic              err_uflow
);
  word_t           regs_q   [NREG];
  word_t           reg_view [NREG];
  logic [NREG-1:0] inc_vec, dec_vec, nonzero, full, uflow, pending;
`ifdef GPR_BYPASS_EN
  logic [NREG-1:0] last;
`endif

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_en) inc_vec[issue_sel] = 1'b1;
    if (wr_en)    dec_vec[wr_sel]    = 1'b1;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    gpr_pend_cnt u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[i]),
      .dec     (dec_vec[i]),
`ifdef GPR_BYPASS_EN
      .last    (last[i]),
`endif
      .nonzero (nonzero[i]),
      .full    (full[i]),
      .uflow   (uflow[i])
    );
  end

`ifdef GPR_BYPASS_EN
  // The final outstanding write landing now (with no new issue) is visible via bypass.
  assign pending = nonzero & ~(last & dec_vec & ~inc_vec);
`else
  assign pending = nonzero;
`endif

  assign issue_full = full[issue_sel];
  assign stall      = rd_req && pending[rd_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      sel_q     <= '0;
      rd_vld    <= 1'b0;
      err_uflow <= 1'b0;
    end else begin
      if (wr_en) regs_q[wr_sel] <= merge_lanes(regs_q[wr_sel], wr_data, wr_be);
      rd_vld <= rd_req && !stall;
      if (rd_req && !stall) sel_q <= rd_sel;
      if (|uflow) err_uflow <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      reg_view[i] = regs_q[i];
`ifdef GPR_BYPASS_EN
      if (wr_en && wr_sel == SEL_W'(i)) reg_view[i] = merge_lanes(regs_q[i], wr_data, wr_be);
`endif
    end
  end

  assign reg0 = reg_view[0];
  assign reg1 = reg_view[1];
  assign reg2 = reg_view[2];
  assign reg3 = reg_view[3];
  assign reg4 = reg_view[4];
  assign reg5 = reg_view[5];
  assign reg6 = reg_view[6];
  assign reg7 = reg_view[7];

  // Issuing to a saturated register is only harmless when a writeback to it cancels out.
  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(issue_en && issue_full && !(wr_en && wr_sel == issue_sel)));
endmodule

// File: tb/tb_gpr16_bank8_sb.sv
// Bench for gpr16_bank8_sb: per-cycle compare against a scoreboard model plus directed literal checks.
// Honours GPR_BYPASS_EN in both the model and the directed expectations.
module tb_gpr16_bank8_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [2:0]  issue_sel;
  logic        issue_full;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [2:0]  rd_sel;
  logic        stall;
  logic [2:0]  sel_q;
  logic        rd_vld;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic        err_uflow;

  int compared = 0;
  int failed   = 0;
  bit checking = 1'b0;

  logic [15:0] m_reg [8];
  int          m_cnt [8];
  bit          m_err;
  logic [2:0]  m_sel;
  bit          m_vld;
  logic [15:0] dut_regs [8];

  always #5 clk = ~clk;

  gpr16_bank8_sb dut (
    .clk(clk), .rst(rst),
    .issue_en(issue_en), .issue_sel(issue_sel), .issue_full(issue_full),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_be(wr_be), .wr_data(wr_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .stall(stall), .sel_q(sel_q), .rd_vld(rd_vld),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .err_uflow(err_uflow)
  );

  assign dut_regs[0] = reg0;
  assign dut_regs[1] = reg1;
  assign dut_regs[2] = reg2;
  assign dut_regs[3] = reg3;
  assign dut_regs[4] = reg4;
  assign dut_regs[5] = reg5;
  assign dut_regs[6] = reg6;
  assign dut_regs[7] = reg7;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] with_lanes(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input logic [1:0] be);
    logic [15:0] r;
    r = old_v;
    if (be[0]) r[7:0]  = new_v[7:0];
    if (be[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  function automatic bit exp_pending(input logic [2:0] r);
    bit p;
    p = (m_cnt[r] > 0);
`ifdef GPR_BYPASS_EN
    if (m_cnt[r] == 1 && wr_en && wr_sel == r && !(issue_en && issue_sel == r)) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic logic [15:0] exp_reg(input int r);
    logic [15:0] v;
    v = m_reg[r];
`ifdef GPR_BYPASS_EN
    if (wr_en && wr_sel == 3'(r)) v = with_lanes(v, wr_data, wr_be);
`endif
    return v;
  endfunction

  // Scoreboard update from the pre-edge inputs.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i] = 16'h0;
        m_cnt[i] = 0;
      end
      m_err = 1'b0;
      m_sel = 3'd0;
      m_vld = 1'b0;
    end else begin
      acc = rd_req && !exp_pending(rd_sel);
      if (wr_en) m_reg[wr_sel] = with_lanes(m_reg[wr_sel], wr_data, wr_be);
      if (!(issue_en && wr_en && issue_sel == wr_sel)) begin
        if (issue_en && m_cnt[issue_sel] < 3) m_cnt[issue_sel]++;
        if (wr_en) begin
          if (m_cnt[wr_sel] > 0) m_cnt[wr_sel]--;
          else m_err = 1'b1;
        end
      end
      m_vld = acc;
      if (acc) m_sel = rd_sel;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("issue_full", issue_full, m_cnt[issue_sel] == 3);
      check_output("stall", stall, rd_req && exp_pending(rd_sel));
      check_output("sel_q", sel_q, m_sel);
      check_output("rd_vld", rd_vld, m_vld);
      check_output("err_uflow", err_uflow, m_err);
      for (int i = 0; i < 8; i++) check_output($sformatf("reg%0d", i), dut_regs[i], exp_reg(i));
    end
  end

  task automatic apply_stimulus(input bit ie, input logic [2:0] is, input bit we, input logic [2:0] ws,
                                input logic [1:0] be, input logic [15:0] wd,
                                input bit rq, input logic [2:0] rs);
    issue_en = ie; issue_sel = is;
    wr_en = we; wr_sel = ws; wr_be = be; wr_data = wd;
    rd_req = rq; rd_sel = rs;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    checking = 1'b1;
    step();

    // Reset in the middle of activity
    rst = 1'b0;
    apply_stimulus(1, 2, 1, 1, 2'b11, 16'hA5A5, 1, 6); step();
    check_output("t1_reg1_written", reg1, 16'hA5A5);
    check_output("t1_uflow_set", err_uflow, 1);
    apply_stimulus(1, 2, 0, 0, 2'b00, 16'h0, 1, 6); step();
    check_output("t1_rdvld_before", rd_vld, 1);
    apply_stimulus(0, 2, 0, 0, 2'b00, 16'h0, 1, 2); #1;
    check_output("t1_stall_cnt2", stall, 1);
    rst = 1'b1;
    apply_stimulus(1, 2, 1, 1, 2'b11, 16'hFFFF, 1, 5); step();
    rst = 1'b0; idle();
    check_output("t1_reg1_cleared", reg1, 16'h0);
    check_output("t1_rdvld_cleared", rd_vld, 0);
    check_output("t1_selq_cleared", sel_q, 0);
    check_output("t1_uflow_cleared", err_uflow, 0);
    apply_stimulus(0, 2, 0, 0, 2'b00, 16'h0, 1, 2); #1;
    check_output("t1_cnt2_cleared", stall, 0);
    step();
    check_output("t1_read_after_rst", sel_q, 2);

    // Byte-lane writes on reg 5
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 5, 0, 0, 2'b00, 16'h0, 0, 0); step();
    end
    apply_stimulus(0, 5, 0, 0, 2'b00, 16'h0, 0, 0); #1;
    check_output("t2_full5", issue_full, 1);
    apply_stimulus(0, 0, 1, 5, 2'b11, 16'h1234, 0, 0); step();
    check_output("t2_reg5_init", reg5, 16'h1234);
    apply_stimulus(0, 0, 1, 5, 2'b01, 16'hBEEF, 0, 0); step();
    check_output("t2_reg5_lo", reg5, 16'h12EF);
    apply_stimulus(0, 0, 1, 5, 2'b10, 16'hBEEF, 0, 0); step();
    check_output("t2_reg5_hi", reg5, 16'hBEEF);
    check_output("t2_no_uflow", err_uflow, 0);

    // Read stalls on a pending write to reg 3
    apply_stimulus(1, 3, 0, 0, 2'b00, 16'h0, 0, 0); step();
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 3); #1;
    check_output("t3_stall", stall, 1);
    step();
    check_output("t3_no_vld", rd_vld, 0);
    apply_stimulus(0, 0, 1, 3, 2'b11, 16'h3333, 1, 3); #1;
`ifdef GPR_BYPASS_EN
    check_output("t3_stall_wb", stall, 0);
    check_output("t3_bypass_reg3", reg3, 16'h3333);
    step();
    idle();
    check_output("t3_vld", rd_vld, 1);
    check_output("t3_selq", sel_q, 3);
`else
    check_output("t3_stall_wb", stall, 1);
    step();
    check_output("t3_no_vld_wb", rd_vld, 0);
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 3); #1;
    check_output("t3_stall_after", stall, 0);
    step();
    idle();
    check_output("t3_vld", rd_vld, 1);
    check_output("t3_selq", sel_q, 3);
`endif
    step();

    // Saturation on reg 7
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 7, 0, 0, 2'b00, 16'h0, 0, 0); step();
    end
    apply_stimulus(0, 7, 0, 0, 2'b00, 16'h0, 0, 0); #1;
    check_output("t4_full", issue_full, 1);
    apply_stimulus(1, 7, 1, 7, 2'b11, 16'h7777, 0, 0); step();
    apply_stimulus(0, 7, 0, 0, 2'b00, 16'h0, 0, 0); #1;
    check_output("t4_full_hold", issue_full, 1);
    apply_stimulus(0, 7, 1, 7, 2'b11, 16'h7000, 0, 0); step();
    apply_stimulus(0, 7, 0, 0, 2'b00, 16'h0, 0, 0); #1;
    check_output("t4_not_full", issue_full, 0);
    apply_stimulus(0, 7, 1, 7, 2'b11, 16'h7001, 0, 0); step();
    apply_stimulus(0, 7, 1, 7, 2'b11, 16'h7002, 0, 0); step();
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 7); #1;
    check_output("t4_drained", stall, 0);
    check_output("t4_uflow_clear", err_uflow, 0);
    step();

    // Underflow on reg 0 is sticky
    apply_stimulus(0, 0, 1, 0, 2'b11, 16'h0F0F, 0, 0); step();
    idle();
    check_output("t5_reg0", reg0, 16'h0F0F);
    check_output("t5_uflow", err_uflow, 1);
    for (int i = 0; i < 10; i++) step();
    check_output("t5_uflow_sticky", err_uflow, 1);

    // Back-to-back reads
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 1); step();
    check_output("t6_sel1", sel_q, 1);
    check_output("t6_vld1", rd_vld, 1);
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 2); step();
    check_output("t6_sel2", sel_q, 2);
    check_output("t6_vld2", rd_vld, 1);
    apply_stimulus(0, 0, 0, 0, 2'b00, 16'h0, 1, 4); step();
    check_output("t6_sel4", sel_q, 4);
    check_output("t6_vld4", rd_vld, 1);
    idle(); step();
    check_output("t6_vld_drop", rd_vld, 0);
    check_output("t6_sel_hold", sel_q, 4);
    step();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
